adder_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit `adder` in the MIPS single-cycle datapath. Requester 0 (PC incrementer) and requester 1 (branch-target calculation) each present an operand pair over a valid/ready handshake. The block grants one requester at a time and drives the granted operands into the external combinational `adder`. It registers the sum and returns it with the requester ID over a valid/ready response channel. One transaction is in flight at a time.

---
 rtl/adder_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// Purpose : two-requester arbiter/sequencer in front of the shared external 32-bit adder.
// Latency : 2 cycles from request accept to rsp_valid; one transaction in flight at a time.
// Backpressure: rsp_ready low holds the response indefinitely; both request readies stay low until it drains.
//
// Ports:
//   clk, reset_n                  clock, asynchronous active-low reset
//   req0_valid/_a/_b/_ready       requester 0 (PC incrementer) operand handshake
//   req1_valid/_a/_b/_ready       requester 1 (branch target) operand handshake
//   add_a, add_b, add_y           operands to / sum from the external combinational adder
//   rsp_valid/_id/_y/_ready       registered sum plus owning requester id
//
// Build option: define ADDER_ARB_RR_EN for round-robin arbitration between
// simultaneous requests; otherwise requester 0 has fixed priority.

module adder_arbiter #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         reset_n,

  input  logic         req0_valid,
  input  logic [n-1:0] req0_a,
  input  logic [n-1:0] req0_b,
  output logic         req0_ready,

  input  logic         req1_valid,
  input  logic [n-1:0] req1_a,
  input  logic [n-1:0] req1_b,
  output logic         req1_ready,

  output logic [n-1:0] add_a,
  output logic [n-1:0] add_b,
  input  logic [n-1:0] add_y,

  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [n-1:0] rsp_y,
  input  logic         rsp_ready
);

`ifdef ADDER_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef struct packed {
    logic [n-1:0] a;
    logic [n-1:0] b;
  } opnd_t;

  logic [1:0] state;
  logic       run;
  logic       last_grant;
  logic       gnt_id;
  opnd_t      op;

  logic       arb_en;
  logic       win_id;

  // run keeps the release cycle quiet: no ready until one full edge has
  // been seen with reset deasserted.
  assign arb_en = run && (state == IDLE) && (req0_valid || req1_valid);

  // Winner selection. With a single requester valid it always wins. With
  // both valid, fixed priority picks 0; round-robin picks whoever did not
  // win last time. last_grant is kept in both builds so the register set
  // does not depend on the arbitration policy.
  always_comb begin
    win_id = 1'b0;
    if (req0_valid && req1_valid) begin
      win_id = RR_EN ? ~last_grant : 1'b0;
    end else begin
      win_id = req1_valid;
    end
  end

  assign req0_ready = arb_en && !win_id;
  assign req1_ready = arb_en &&  win_id;

  // The captured operands feed the adder directly. They are only reloaded
  // on accept, so the adder inputs hold their last value outside EXEC.
  assign add_a = op.a;
  assign add_b = op.b;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      run        <= 1'b0;
      op         <= '0;
      gnt_id     <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_y      <= '0;
    end else begin
      run <= 1'b1;
      case (state)
        IDLE: begin
          if (arb_en) begin
            op         <= win_id ? {req1_a, req1_b} : {req0_a, req0_b};
            gnt_id     <= win_id;
            last_grant <= win_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // Carry-out of the external adder is not visible here; the sum
          // is taken modulo 2^n as delivered.
          rsp_y     <= add_y;
          rsp_id    <= gnt_id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
